// File: rtl/core_pkg.sv
// Shared encodings for the core's pipeline control: forwarding selects,
// result-source codes and the hazard controller's sequencing states.
package core_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register identifiers and status in,
// stall/flush/forward controls and statistics out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E;
    logic [4:0]       rdE, rdM, rdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW;
    logic             PCSrcE;
    logic             MemReqM;
    logic             dmem_ready;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_timeout, stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, mem_timeout, stall_cnt, flush_cnt, wait_cnt
    );

endinterface

// File: rtl/hazard_stat_cnt.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
module hazard_stat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: forwarding, load-use
// bubbles, branch flushes, data-memory wait freeze, timeout flag, statistics.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    hz_state_e   state_q;
    logic [TO_W-1:0] to_cnt_q;
    logic        mem_timeout_q;

    logic        lw_haz;
    logic        mem_stall;
    logic        branch_flush;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;

    always_comb begin
        bus.ForwardAE = FWD_RF;
        if (bus.RegWriteM && (bus.rdM != 5'd0) && (bus.rdM == bus.rs1E))
            bus.ForwardAE = FWD_M;
        else if (bus.RegWriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs1E))
            bus.ForwardAE = FWD_W;

        bus.ForwardBE = FWD_RF;
        if (bus.RegWriteM && (bus.rdM != 5'd0) && (bus.rdM == bus.rs2E))
            bus.ForwardBE = FWD_M;
        else if (bus.RegWriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs2E))
            bus.ForwardBE = FWD_W;
    end

    assign lw_haz = (bus.ResultSrcE == RES_LOAD) && (bus.rdE != 5'd0) &&
                    ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));

    // In WAIT the stall drops combinationally on dmem_ready (zero-cycle release).
    assign mem_stall = (state_q == WAIT) ? !bus.dmem_ready
                                         : (bus.MemReqM && !bus.dmem_ready);

    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;
        branch_flush = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (bus.PCSrcE) begin
            flush_d      = 1'b1;
            flush_e      = 1'b1;
            branch_flush = 1'b1;
        end else if (lw_haz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign bus.StallF      = stall_f;
    assign bus.StallD      = stall_d;
    assign bus.StallE      = stall_e;
    assign bus.StallM      = stall_m;
    assign bus.FlushD      = flush_d;
    assign bus.FlushE      = flush_e;
    assign bus.FlushW      = flush_w;
    assign bus.mem_timeout = mem_timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            to_cnt_q      <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    to_cnt_q <= '0;
                    if (bus.MemReqM && !bus.dmem_ready) state_q <= WAIT;
                end
                WAIT: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (!bus.dmem_ready && (to_cnt_q == TO_W'(TIMEOUT - 1)))
                        mem_timeout_q <= 1'b1;
                    if (bus.dmem_ready) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    hazard_stat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (stall_f),
        .cnt_o (bus.stall_cnt)
    );

    hazard_stat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (branch_flush),
        .cnt_o (bus.flush_cnt)
    );

    hazard_stat_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (mem_stall),
        .cnt_o (bus.wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int unsigned CW   = 4;
    localparam int unsigned TOUT = 4;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, se, sm, fd, fe, fw;
    } outs_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // model state: waiting flag, wait length, sticky timeout, counters
    bit m_wait;
    int m_len;
    bit m_to;
    int m_stall, m_flush, m_wcnt;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TOUT), .TO_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (bus.RegWriteM && bus.rdM != 0 && bus.rdM == rs) return 2'b10;
        if (bus.RegWriteW && bus.rdW != 0 && bus.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_mem_stall();
        if (m_wait) return !bus.dmem_ready;
        return bus.MemReqM && !bus.dmem_ready;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        bit    lw;
        o    = '0;
        o.fa = exp_fwd(bus.rs1E);
        o.fb = exp_fwd(bus.rs2E);
        lw   = (bus.ResultSrcE == 2'b01) && bus.rdE != 0 &&
               (bus.rdE == bus.rs1D || bus.rdE == bus.rs2D);
        if (exp_mem_stall()) begin
            o.sf = 1; o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1;
        end else if (bus.PCSrcE) begin
            o.fd = 1; o.fe = 1;
        end else if (lw) begin
            o.sf = 1; o.sd = 1; o.fe = 1;
        end
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o = {bus.ForwardAE, bus.ForwardBE, bus.StallF, bus.StallD, bus.StallE,
             bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};
        return o;
    endfunction

    // one clock edge; the model advances using the inputs present at the edge
    task automatic tick();
        outs_t e;
        bit    ms;
        e  = model_outs();
        ms = exp_mem_stall();
        @(posedge clk);
        if (reset) begin
            m_wait = 0; m_len = 0; m_to = 0;
            m_stall = 0; m_flush = 0; m_wcnt = 0;
        end else begin
            if (e.sf && m_stall < CMAX) m_stall++;
            if (e.fd && m_flush < CMAX) m_flush++;
            if (ms && m_wcnt < CMAX) m_wcnt++;
            if (m_wait && !bus.dmem_ready) begin
                m_len++;
                if (m_len >= TOUT) m_to = 1;
            end else begin
                m_len = 0;
            end
            m_wait = m_wait ? !bus.dmem_ready : (bus.MemReqM && !bus.dmem_ready);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.rs1D = 0; bus.rs2D = 0; bus.rs1E = 0; bus.rs2E = 0;
        bus.rdE = 0; bus.rdM = 0; bus.rdW = 0; bus.ResultSrcE = 0;
        bus.RegWriteM = 0; bus.RegWriteW = 0; bus.PCSrcE = 0;
        bus.MemReqM = 0; bus.dmem_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        bus.MemReqM = 1; bus.dmem_ready = 0;
        tick();
        tick();
        reset = 0;
        idle_inputs();
        #1;
        total++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_counters got=%0h/%0h/%0h exp=0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
        end
        total++;
        if (bus.mem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_timeout got=%b exp=0", bus.mem_timeout);
        end
        total++;
        if (dut_outs() !== outs_t'(0)) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", dut_outs());
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        bus.RegWriteM = 1; bus.rdM = 5; bus.RegWriteW = 1; bus.rdW = 5; bus.rs1E = 5;
        #1;
        total++;
        if (bus.ForwardAE !== 2'b10) begin
            bad++; $display("FAIL fwd_m_priority got=%b exp=10", bus.ForwardAE);
        end
        bus.rdM = 0;
        #1;
        total++;
        if (bus.ForwardAE !== 2'b01) begin
            bad++; $display("FAIL fwd_w_when_rdm_x0 got=%b exp=01", bus.ForwardAE);
        end
        bus.rs2E = 0; bus.rdW = 0;
        #1;
        total++;
        if (bus.ForwardBE !== 2'b00) begin
            bad++; $display("FAIL fwd_x0_never got=%b exp=00", bus.ForwardBE);
        end
        bus.rdM = 9; bus.rs2E = 9; bus.RegWriteM = 0; bus.rdW = 9;
        #1;
        total++;
        if (bus.ForwardBE !== 2'b01) begin
            bad++; $display("FAIL fwd_b_w_only got=%b exp=01", bus.ForwardBE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ResultSrcE = 2'b01; bus.rdE = 3; bus.rs2D = 3;
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.StallE} !== 4'b1110) begin
            bad++;
            $display("FAIL load_use_bubble got=%b exp=1110",
                     {bus.StallF, bus.StallD, bus.FlushE, bus.StallE});
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin
            bad++;
            $display("FAIL load_use_one_cycle got=%b exp=000",
                     {bus.StallF, bus.StallD, bus.FlushE});
        end
        total++;
        if (bus.stall_cnt !== CW'(1)) begin
            bad++; $display("FAIL load_use_stall_cnt got=%0d exp=1", bus.stall_cnt);
        end
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        bus.ResultSrcE = 2'b01; bus.rdE = 7; bus.rs1D = 7; bus.PCSrcE = 1;
        #1;
        total++;
        if ({bus.FlushD, bus.FlushE, bus.StallF, bus.StallD} !== 4'b1100) begin
            bad++;
            $display("FAIL branch_over_load got=%b exp=1100",
                     {bus.FlushD, bus.FlushE, bus.StallF, bus.StallD});
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if ({bus.flush_cnt, bus.stall_cnt} !== {CW'(1), CW'(0)}) begin
            bad++;
            $display("FAIL branch_counters got=flush %0d stall %0d exp=flush 1 stall 0",
                     bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        int stalled;
        do_reset();
        stalled = 0;
        bus.MemReqM = 1; bus.dmem_ready = 0; bus.PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW,
                 bus.FlushD, bus.FlushE} == 7'b1111100) stalled++;
            tick();
        end
        bus.dmem_ready = 1;
        #1;
        total++;
        if (stalled != 3 || bus.StallF !== 1'b0) begin
            bad++;
            $display("FAIL mem_wait_freeze got=%0d stall cycles, release StallF=%b exp=3, 0",
                     stalled, bus.StallF);
        end
        total++;
        if ({bus.FlushD, bus.FlushE} !== 2'b11) begin
            bad++;
            $display("FAIL mem_wait_held_branch got=%b exp=11", {bus.FlushD, bus.FlushE});
        end
        tick();
        idle_inputs();
        bus.dmem_ready = 0;
        #1;
        total++;
        if (bus.StallF !== 1'b0) begin
            bad++; $display("FAIL mem_wait_back_in_run got StallF=%b exp=0", bus.StallF);
        end
        total++;
        if ({bus.wait_cnt, bus.flush_cnt} !== {CW'(3), CW'(1)}) begin
            bad++;
            $display("FAIL mem_wait_counters got=wait %0d flush %0d exp=wait 3 flush 1",
                     bus.wait_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.MemReqM = 1; bus.dmem_ready = 0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (bus.mem_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_early got=%b exp=0", bus.mem_timeout);
        end
        tick();
        total++;
        if (bus.mem_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_rise got=%b exp=1", bus.mem_timeout);
        end
        total++;
        if (bus.StallF !== 1'b1) begin
            bad++; $display("FAIL timeout_keeps_waiting got StallF=%b exp=1", bus.StallF);
        end
        bus.dmem_ready = 1;
        tick();
        bus.MemReqM = 0;
        tick();
        total++;
        if (bus.mem_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sticky got=%b exp=1", bus.mem_timeout);
        end
        // reset while waiting, memory still not ready
        bus.MemReqM = 1; bus.dmem_ready = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        bus.MemReqM = 0;
        #1;
        total++;
        if ({bus.mem_timeout, bus.StallF, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_mid_wait got to=%b stall=%b cnt=%0d/%0d/%0d exp=all 0",
                     bus.mem_timeout, bus.StallF, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.ResultSrcE = 2'b01; bus.rdE = 4; bus.rs1D = 4;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (bus.stall_cnt !== CW'(CMAX)) begin
            bad++; $display("FAIL stall_cnt_saturate got=%0d exp=%0d", bus.stall_cnt, CMAX);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        outs_t e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset          = ($urandom_range(0, 59) == 0);
            bus.rs1D       = 5'($urandom_range(0, 3));
            bus.rs2D       = 5'($urandom_range(0, 3));
            bus.rs1E       = 5'($urandom_range(0, 3));
            bus.rs2E       = 5'($urandom_range(0, 3));
            bus.rdE        = 5'($urandom_range(0, 3));
            bus.rdM        = 5'($urandom_range(0, 3));
            bus.rdW        = 5'($urandom_range(0, 3));
            bus.ResultSrcE = 2'($urandom_range(0, 3));
            bus.RegWriteM  = 1'($urandom_range(0, 1));
            bus.RegWriteW  = 1'($urandom_range(0, 1));
            bus.PCSrcE     = ($urandom_range(0, 5) == 0);
            bus.MemReqM    = ($urandom_range(0, 3) == 0);
            bus.dmem_ready = ($urandom_range(0, 9) < 4);
            #1;
            e = model_outs();
            total++;
            if (dut_outs() !== e) begin
                bad++; $display("FAIL rand_outputs cycle=%0d got=%h exp=%h", c, dut_outs(), e);
            end
            tick();
            total++;
            if ({bus.mem_timeout, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !==
                {m_to, CW'(m_stall), CW'(m_flush), CW'(m_wcnt)}) begin
                bad++;
                $display("FAIL rand_state cycle=%0d got=%b %0d %0d %0d exp=%b %0d %0d %0d", c,
                         bus.mem_timeout, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt,
                         m_to, m_stall, m_flush, m_wcnt);
            end
        end
        reset = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 0;
        m_wait = 0; m_len = 0; m_to = 0;
        m_stall = 0; m_flush = 0; m_wcnt = 0;
        idle_inputs();
        #2;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_vs_load();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
